port_input_buffer: RTL and testbench



---
 rtl/router_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/port_input_buffer.sv | 154 +++++++++++++++
 tb/tb_port_input_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module  : router_pkg
// Purpose : Shared router definitions. These are the flit_id encodings, the
//           length field width, the flit_id field width and the input-buffer
//           framer state type.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package router_pkg;

  localparam int FLIT_ID_W = 3;
  localparam int LEN_W     = 12;

  localparam logic [FLIT_ID_W-1:0] FLIT_HEADER = 3'b001;
  localparam logic [FLIT_ID_W-1:0] FLIT_BODY   = 3'b010;
  localparam logic [FLIT_ID_W-1:0] FLIT_TAIL   = 3'b100;

  // Framer state: IDLE means no packet is open. PKT means a header has
  // been forwarded and its tail has not been seen yet.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PKT  = 1'b1
  } pib_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Purpose : Single-clock circular-buffer FIFO with a combinational head.
//           A written entry becomes visible at the head one cycle later.
// Ports   : clk, rst             - clock, synchronous active-high reset
//           push, push_data      - write request and data (ignored when full)
//           pop                  - read request (ignored when empty)
//           head                 - entry at rd_ptr
//           full, empty, count   - occupancy status
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A push into a full buffer is rejected even if a pop happens in the
  // same cycle. Acceptance depends only on the registered occupancy.
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !rd_en) begin
        count <= count + 1'b1;
      end else if (rd_en && !wr_en) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/port_input_buffer.sv
`default_nettype none
// ============================================================================
// Module  : port_input_buffer
// Purpose : Per-port input FIFO and packet framer ahead of the router arbiter.
//           It requests the arbiter for the whole of a packet and forwards one
//           flit per granted cycle. It discards malformed head flits.
// Ports   : clk, rst             - clock, synchronous active-high reset
//           in_valid, in_data    - upstream flit
//           in_ready             - buffer not full
//           grant                - arbiter grant for this port
//           req                  - request to arbiter
//           flit_id, length      - head flit type / length (0 when empty)
//           out_valid, out_data  - flit forwarded to the crossbar
//           drop                 - one-cycle pulse per discarded flit
//           drop_cnt             - saturating drop counter (only when
//                                  PORT_INPUT_BUFFER_DROP_CNT_EN is defined)
// Revision: 1.0 - initial release
// ============================================================================
module port_input_buffer
  import router_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  input  logic                 grant,
  output logic                 req,
  output logic [FLIT_ID_W-1:0] flit_id,
  output logic [LEN_W-1:0]     length,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic                 drop
`ifdef PORT_INPUT_BUFFER_DROP_CNT_EN
  ,
  output logic [15:0]          drop_cnt
`endif
);

  localparam int ID_LSB = DATA_W - FLIT_ID_W;

  logic [DATA_W-1:0]    head;
  logic                 full;
  logic                 empty;
  logic [AW:0]          count;
  logic                 pop;
  logic [FLIT_ID_W-1:0] head_id;
  pib_state_t           state;
  pib_state_t           state_nxt;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign in_ready = !full;
  assign head_id  = head[DATA_W-1:ID_LSB];
  assign flit_id  = empty ? '0 : head_id;
  assign length   = empty ? '0 : head[LEN_W-1:0];
  // Gate forwarded data so the crossbar sees zero when nothing is forwarded.
  // This also covers reset, because the storage array is never cleared.
  assign out_data = out_valid ? head : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    pop       = 1'b0;
    out_valid = 1'b0;
    drop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          if (head_id == FLIT_HEADER) begin
            req = 1'b1;
            if (grant) begin
              pop       = 1'b1;
              out_valid = 1'b1;
              state_nxt = PKT;
            end
          end else begin
            // A packet cannot start with anything but a header. The flit
            // is discarded without waiting for a grant.
            pop  = 1'b1;
            drop = 1'b1;
          end
        end
      end
      PKT: begin
        // When the buffer is empty mid-packet, req drops and the state holds.
        // The arbiter's timer covers the gap.
        if (!empty) begin
          req = 1'b1;
          if (grant) begin
            pop = 1'b1;
            case (head_id)
              FLIT_TAIL: begin
                out_valid = 1'b1;
                state_nxt = IDLE;
              end
              FLIT_BODY: begin
                out_valid = 1'b1;
              end
              FLIT_HEADER: begin
                // The previous tail was lost. Forward the new header and
                // keep the packet open.
                out_valid = 1'b1;
                drop      = 1'b1;
              end
              default: begin
                drop = 1'b1;
              end
            endcase
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PORT_INPUT_BUFFER_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_port_input_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_port_input_buffer
// Purpose : Directed self-checking bench for port_input_buffer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_port_input_buffer;
  import router_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              grant;
  logic              req;
  logic [2:0]        flit_id;
  logic [11:0]       length;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              drop;
`ifdef PORT_INPUT_BUFFER_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  port_input_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .grant     (grant),
    .req       (req),
    .flit_id   (flit_id),
    .length    (length),
    .out_valid (out_valid),
    .out_data  (out_data),
    .drop      (drop)
`ifdef PORT_INPUT_BUFFER_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] id, input logic [11:0] len,
                                     input logic [16:0] pay);
    return {id, pay, len};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one flit across a single clock edge, then settle.
  task automatic push(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
  endtask

  logic [31:0] h1, b1, t1, h2, hx, tx, bx;

  initial begin
    h1 = mk(3'b001, 12'd5, 17'h00011);
    b1 = mk(3'b010, 12'd0, 17'h00022);
    t1 = mk(3'b100, 12'd0, 17'h00033);
    h2 = mk(3'b001, 12'd8, 17'h00044);
    bx = mk(3'b010, 12'd0, 17'h00055);
    hx = mk(3'b001, 12'd3, 17'h00066);
    tx = mk(3'b100, 12'd0, 17'h00077);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; grant = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_req", 32'(req), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_flit_id", 32'(flit_id), 32'd0);
    check("rst_length", 32'(length), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_count", 32'(dut.u_fifo.count), 32'd0);

    // Packet stored with no grant
    push(h1);
    check("hdr_req", 32'(req), 32'd1);
    check("hdr_flit_id", 32'(flit_id), 32'd1);
    check("hdr_length", 32'(length), 32'd5);
    push(b1);
    push(t1);
    check("pkt_count", 32'(dut.u_fifo.count), 32'd3);
    check("pkt_in_ready", 32'(in_ready), 32'd1);
    check("pkt_no_fwd", 32'(out_valid), 32'd0);

    // Grant held for three cycles forwards header, body, tail
    grant = 1'b1;
    #1;
    check("fwd0_valid", 32'(out_valid), 32'd1);
    check("fwd0_data", out_data, h1);
    step();
    check("fwd1_valid", 32'(out_valid), 32'd1);
    check("fwd1_data", out_data, b1);
    check("fwd1_state", 32'(dut.state), 32'(PKT));
    step();
    check("fwd2_valid", 32'(out_valid), 32'd1);
    check("fwd2_data", out_data, t1);
    step();
    grant = 1'b0;
    #1;
    check("end_req", 32'(req), 32'd0);
    check("end_state", 32'(dut.state), 32'(IDLE));
    check("end_count", 32'(dut.u_fifo.count), 32'd0);

    // Fill the buffer (pointers wrap)
    push(h2);
    for (int i = 0; i < DEPTH - 1; i++) push(bx);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_count", 32'(dut.u_fifo.count), 32'd8);
    push(tx);
    check("full_reject", 32'(dut.u_fifo.count), 32'd8);
    in_valid = 1'b1;
    in_data  = tx;
    grant    = 1'b1;
    #1;
    check("fullpop_valid", 32'(out_valid), 32'd1);
    check("fullpop_data", out_data, h2);
    step();
    in_valid = 1'b0;
    #1;
    check("fullpop_count", 32'(dut.u_fifo.count), 32'd7);
    repeat (7) @(posedge clk);
    #1;
    // The buffer is dry mid-packet
    check("dry_count", 32'(dut.u_fifo.count), 32'd0);
    check("dry_req", 32'(req), 32'd0);
    check("dry_state", 32'(dut.state), 32'(PKT));
    grant = 1'b0;
    push(tx);
    check("resume_req", 32'(req), 32'd1);
    grant = 1'b1;
    #1;
    check("resume_valid", 32'(out_valid), 32'd1);
    check("resume_data", out_data, tx);
    step();
    grant = 1'b0;
    #1;
    check("resume_state", 32'(dut.state), 32'(IDLE));

    // A body flit at the head while IDLE is discarded
    push(bx);
    check("idle_drop", 32'(drop), 32'd1);
    check("idle_drop_nofwd", 32'(out_valid), 32'd0);
    check("idle_drop_req", 32'(req), 32'd0);
    step();
    check("idle_drop_count", 32'(dut.u_fifo.count), 32'd0);
    check("idle_drop_pulse", 32'(drop), 32'd0);
    check("empty_flit_id", 32'(flit_id), 32'd0);
`ifdef PORT_INPUT_BUFFER_DROP_CNT_EN
    check("drop_cnt_1", 32'(drop_cnt), 32'd1);
`endif

    // Header and invalid flits while a packet is open
    push(hx);
    grant = 1'b1;
    step();
    grant = 1'b0;
    push(h1);
    grant = 1'b1;
    #1;
    check("pkt_hdr_drop", 32'(drop), 32'd1);
    check("pkt_hdr_fwd", 32'(out_valid), 32'd1);
    check("pkt_hdr_data", out_data, h1);
    step();
    grant = 1'b0;
    push(mk(3'b111, 12'd0, 17'h00099));
    grant = 1'b1;
    #1;
    check("pkt_inv_drop", 32'(drop), 32'd1);
    check("pkt_inv_nofwd", 32'(out_valid), 32'd0);
    step();
    grant = 1'b0;
    #1;
    check("pkt_inv_state", 32'(dut.state), 32'(PKT));
    push(tx);
    grant = 1'b1;
    step();
    grant = 1'b0;
    #1;
    check("pkt_close_state", 32'(dut.state), 32'(IDLE));
`ifdef PORT_INPUT_BUFFER_DROP_CNT_EN
    check("drop_cnt_3", 32'(drop_cnt), 32'd3);
`endif

    // Reset while a packet is open with four flits stored
    push(hx);
    grant = 1'b1;
    step();
    grant = 1'b0;
    for (int i = 0; i < 4; i++) push(bx);
    check("pre_rst_count", 32'(dut.u_fifo.count), 32'd4);
    rst = 1'b1;
    step();
    check("midrst_count", 32'(dut.u_fifo.count), 32'd0);
    check("midrst_req", 32'(req), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
